// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the 7-segment scan display.
//   SEG_BLANK   : active-low "all segments off" pattern.
//   SEG_A..G    : bit positions of each segment in the 7-bit pattern {g,f,e,d,c,b,a}.
//   HEX_GLYPHS  : active-low glyphs for nibbles 0..F (A, b, C, d, E, F).
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index [n] holds the active-low pattern for nibble n.
   localparam logic [15:0][6:0] HEX_GLYPHS = {
      7'h0E,  // F
      7'h06,  // E
      7'h21,  // d
      7'h46,  // C
      7'h03,  // b
      7'h08,  // A
      7'h10,  // 9
      7'h00,  // 8
      7'h78,  // 7
      7'h02,  // 6
      7'h12,  // 5
      7'h19,  // 4
      7'h30,  // 3
      7'h24,  // 2
      7'h79,  // 1
      7'h40   // 0
   };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if -- load bus from the value source into the scan mux.
//   load_valid : single-cycle strobe, captures load_data.
//   load_data  : 4*DIGITS bits, nibble i drives digit i.
// Modports: master = value source, slave = display mux.
interface seg7_scan_mux_if #(
   parameter int DIGITS = 4
);
   logic                  load_valid;
   logic [4*DIGITS-1:0]   load_data;

   modport master (output load_valid, output load_data);
   modport slave  (input  load_valid, input  load_data);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode -- combinational nibble to active-low 7-segment pattern.
//   nib : hex digit in
//   seg : {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX_GLYPHS[nib];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux -- time-multiplexes a DIGITS-digit hex value onto a
// common-anode 7-segment display. Each digit is shown for 2**PRESCALE_W
// cycles, the first BLANK_CYCLES of which have all anodes off. New values
// are staged and only take effect at a frame boundary, so a frame never
// mixes old and new digits.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   ld          : load bus (slave), last write before a frame boundary wins
//   dp_mask     : decimal point enables, 1 = on, sampled live
//   an          : anode enables, active-low
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   frame_done  : one-cycle pulse after the last digit's dwell ends
//
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown; anode timing and dp are unaffected).
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int PRESCALE_W   = 16,
   parameter int DIGITS       = 4,
   parameter int BLANK_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_mux_if.slave     ld,
   input  logic [DIGITS-1:0]  dp_mask,
   output logic [DIGITS-1:0]  an,
   output logic [6:0]         seg,
   output logic               dp,
   output logic               frame_done
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PRESCALE_W-1:0]   presc;
   logic [IDX_W-1:0]        idx;
   logic [DIGITS-1:0][3:0]  shadow;
   logic [DIGITS-1:0][3:0]  pending;
   logic                    pend_v;

   logic       wrap;
   logic       frame_end;
   logic       blank;
   logic [6:0] dec_seg;
   logic [6:0] seg_nxt;

   assign wrap      = (presc == {PRESCALE_W{1'b1}});
   assign frame_end = wrap && (idx == IDX_LAST);
   assign blank     = (presc < PRESCALE_W'(BLANK_CYCLES));

   seg7_hex_decode u_dec (
      .nib (shadow[idx]),
      .seg (dec_seg)
   );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more-significant digit
   // are zero; digit 0 always shows so a zero value reads "0".
   logic upper_zero;

   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((i >= int'(idx)) && (shadow[i] != 4'h0)) upper_zero = 1'b0;
      end
      seg_nxt = ((idx != '0) && upper_zero) ? SEG_BLANK : dec_seg;
   end
`else
   assign seg_nxt = dec_seg;
`endif

   // Scan counters
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= presc + 1'b1;
         if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Value staging: a load landing on the boundary cycle goes straight to
   // shadow, otherwise it waits in pending until the next boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow  <= '0;
         pending <= '0;
         pend_v  <= 1'b0;
      end else begin
         if (ld.load_valid) pending <= ld.load_data;
         if (frame_end) begin
            if (ld.load_valid) shadow <= ld.load_data;
            else if (pend_v)   shadow <= pending;
            pend_v <= 1'b0;
         end else if (ld.load_valid) begin
            pend_v <= 1'b1;
         end
      end
   end

   // Registered outputs, one cycle behind the scan state
   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= '1;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (blank) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
         end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_nxt;
            dp  <= ~dp_mask[idx];
         end
      end
   end

endmodule
